// File: rtl/spram_16kx16_pkg.sv
// Shared geometry constants for the 16Kx16 single-port RAM and its users.
package spram_16kx16_pkg;

  localparam int unsigned SPRAM_ADDR_W  = 14;
  localparam int unsigned SPRAM_DATA_W  = 16;
  localparam int unsigned SPRAM_NIBBLES = SPRAM_DATA_W / 4;

  localparam logic [SPRAM_NIBBLES-1:0] SPRAM_MASK_FULL = 4'b0000;

endpackage

// File: rtl/spram_16kx16_if.sv
// iCE40 SPRAM-compatible access bus; master drives the request, slave returns DATAOUT.
interface spram_16kx16_if
  import spram_16kx16_pkg::*;
#(
  parameter int unsigned ADDR_W = SPRAM_ADDR_W,
  parameter int unsigned DATA_W = SPRAM_DATA_W
);

  logic [ADDR_W-1:0]   ADDRESS;
  logic [DATA_W-1:0]   DATAIN;
  logic                WREN;
  logic [DATA_W/4-1:0] MASKWREN;
  logic                CHIPSELECT;
  logic                STANDBY;
  logic                SLEEP;
  logic                POWEROFF;
  logic [DATA_W-1:0]   DATAOUT;

  modport master (
    output ADDRESS, DATAIN, WREN, MASKWREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    input  DATAOUT
  );

  modport slave (
    input  ADDRESS, DATAIN, WREN, MASKWREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    output DATAOUT
  );

endinterface

// File: rtl/spram_16kx16_nibble_we.sv
// Per-nibble write enables: a set mask bit blocks its nibble.
module spram_16kx16_nibble_we
  import spram_16kx16_pkg::*;
#(
  parameter int unsigned Nibbles = SPRAM_NIBBLES
) (
  input  logic               en_i,
  input  logic [Nibbles-1:0] mask_i,
  output logic [Nibbles-1:0] we_o
);

  always_comb begin
    we_o = {Nibbles{en_i}} & ~mask_i;
  end

endmodule

// File: rtl/spram_16kx16.sv
// 16Kx16 single-port synchronous RAM with nibble write mask and iCE40 SPRAM power controls.
module spram_16kx16
  import spram_16kx16_pkg::*;
#(
  parameter int unsigned ADDR_W    = SPRAM_ADDR_W,
  parameter int unsigned DATA_W    = SPRAM_DATA_W,
  parameter string       INIT_FILE = ""
) (
  input logic            clk,
  input logic            rst,
  spram_16kx16_if.slave  bus
);

  localparam int unsigned Nibbles = DATA_W / 4;

  typedef logic [DATA_W-1:0] mem_t [2**ADDR_W];

  // Zero-initialised so unwritten words never read as X.
  mem_t mem = '{default: '0};

  logic               active;
  logic               power_down;
  logic [Nibbles-1:0] nib_we;
  logic [DATA_W-1:0]  dout_q;

  always_comb begin
    active     = bus.CHIPSELECT & ~bus.STANDBY & ~bus.SLEEP & bus.POWEROFF;
    power_down = bus.SLEEP | ~bus.POWEROFF;
  end

  spram_16kx16_nibble_we #(
    .Nibbles (Nibbles)
  ) u_nibble_we (
    .en_i   (active & bus.WREN & ~rst),
    .mask_i (bus.MASKWREN),
    .we_o   (nib_we)
  );

  // Write port and output register share one process so tools map it onto block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      if (power_down) begin
        dout_q <= '0;
      end else if (active && !bus.WREN) begin
        dout_q <= mem[bus.ADDRESS];
      end
      for (int n = 0; n < Nibbles; n++) begin
        if (nib_we[n]) mem[bus.ADDRESS][4*n +: 4] <= bus.DATAIN[4*n +: 4];
      end
    end
  end

  assign bus.DATAOUT = dout_q;

endmodule

// File: tb/tb_spram_16kx16.sv
// Directed bench for spram_16kx16: writes, masks, boundaries, power controls and reset.
module tb_spram_16kx16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  spram_16kx16_if #(.ADDR_W(14), .DATA_W(16)) bus ();

  spram_16kx16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [13:0] a, input logic [15:0] d, input logic we,
                       input logic [3:0] m, input logic cs);
    bus.ADDRESS    = a;
    bus.DATAIN     = d;
    bus.WREN       = we;
    bus.MASKWREN   = m;
    bus.CHIPSELECT = cs;
    cyc();
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    drive(a, d, 1'b1, m, 1'b1);
  endtask

  task automatic rd(input logic [13:0] a);
    drive(a, 16'h0000, 1'b0, 4'hF, 1'b1);
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    n_checks++;
    assert (bus.DATAOUT === exp) else begin
      n_fail++;
      $error("FAIL %s: DATAOUT=%h expected %h", tag, bus.DATAOUT, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.ADDRESS    = '0;
    bus.DATAIN     = '0;
    bus.WREN       = 1'b0;
    bus.MASKWREN   = 4'hF;
    bus.CHIPSELECT = 1'b0;
    bus.STANDBY    = 1'b0;
    bus.SLEEP      = 1'b0;
    bus.POWEROFF   = 1'b1;
    cyc();
    cyc();
    check("reset_dataout", 16'h0000);
    rst = 1'b0;

    rd(14'h0000);            check("read0_after_reset", 16'h0000);

    wr(14'h0005, 16'hBEEF, 4'b0000);
    rd(14'h0005);            check("full_write_readback", 16'hBEEF);

    wr(14'h0010, 16'hFFFF, 4'b0000);
    wr(14'h0010, 16'h1234, 4'b0101);
    rd(14'h0010);            check("nibble_mask_0101", 16'h1F3F);
    wr(14'h0010, 16'h0000, 4'b1111);
    rd(14'h0010);            check("nibble_mask_1111", 16'h1F3F);

    wr(14'h3FFF, 16'hA5A5, 4'b0000);
    wr(14'h0000, 16'h5A5A, 4'b0000);
    rd(14'h3FFF);            check("top_address", 16'hA5A5);
    rd(14'h0000);            check("bottom_address", 16'h5A5A);

    drive(14'h0005, 16'h0000, 1'b1, 4'b0000, 1'b0);
    rd(14'h0005);            check("cs0_write_ignored", 16'hBEEF);

    bus.STANDBY = 1'b1;
    rd(14'h0000);            check("standby_holds", 16'hBEEF);
    wr(14'h0005, 16'h0000, 4'b0000);
    check("standby_write_hold", 16'hBEEF);
    bus.STANDBY = 1'b0;

    bus.SLEEP = 1'b1;
    rd(14'h0000);            check("sleep_zeroes", 16'h0000);
    wr(14'h0005, 16'h0000, 4'b0000);
    bus.SLEEP = 1'b0;
    rd(14'h0005);            check("after_sleep_read", 16'hBEEF);

    wr(14'h0020, 16'h1111, 4'b0000);
    check("write_holds_dataout", 16'hBEEF);
    rd(14'h0020);            check("read_after_write_b2b", 16'h1111);

    bus.POWEROFF = 1'b0;
    rd(14'h0020);            check("poweroff_zeroes", 16'h0000);
    wr(14'h0005, 16'h0000, 4'b0000);
    bus.POWEROFF = 1'b1;
    rd(14'h0005);            check("poweroff_write_ignored", 16'hBEEF);

    rst = 1'b1;
    rd(14'h0010);            check("reset_during_read", 16'h0000);
    wr(14'h0005, 16'h0000, 4'b0000);
    rst = 1'b0;
    rd(14'h0005);            check("reset_blocks_write", 16'hBEEF);
    rd(14'h0010);            check("array_survives_reset", 16'h1F3F);

    wr(14'h0030, 16'hC0DE, 4'b1000);
    rd(14'h0030);            check("partial_write_unwritten", 16'h00DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
